// File: rtl/filterbank_sequencer.sv
// rtl/filterbank_sequencer.sv - Sample-write / tap-walk / output-load sequencer for the FIR filter bank

module filterbank_sequencer #(
  parameter int NTAPS   = 128,
  parameter int MAC_LAT = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       din_enable,
  input  logic                       overrun_clear,
  output logic                       sample_we,
  output logic [$clog2(NTAPS)-1:0]   sample_waddr,
  output logic [$clog2(NTAPS)-1:0]   sample_raddr0,
  output logic [$clog2(NTAPS)-1:0]   sample_raddr1,
  output logic [$clog2(NTAPS)-2:0]   coeffaddress,
  output logic                       mac_enable,
  output logic                       mac_clear,
  output logic                       mac_last,
  output logic                       dout_load,
  output logic                       busy,
  output logic                       overrun
);

  localparam int AW = $clog2(NTAPS);
  localparam int KW = AW - 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NTAPS / 2 - 1);
  localparam logic [DW-1:0] D_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state;
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_base, w_base;
  logic [KW-1:0]   r_k, w_k;
  logic [DW-1:0]   r_drain, w_drain;
  logic [KW-1:0]   r_coeff, w_coeff;
  logic [AW-1:0]   r_raddr0, w_raddr0;
  logic [AW-1:0]   r_raddr1, w_raddr1;
  logic            r_mac_enable, w_mac_enable;
  logic            r_mac_clear, w_mac_clear;
  logic            r_mac_last, w_mac_last;
  logic            r_dout_load, w_dout_load;
  logic            r_busy, w_busy;
  logic            r_overrun, w_overrun;
  logic            w_run;
  logic [AW-1:0]   w_even, w_odd;

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    w_state      = r_state;
    w_base       = r_base;
    w_k          = r_k;
    w_drain      = r_drain;
    w_coeff      = r_coeff;
    w_raddr0     = r_raddr0;
    w_raddr1     = r_raddr1;
    w_mac_enable = 1'b0;
    w_mac_clear  = 1'b0;
    w_mac_last   = 1'b0;
    w_dout_load  = 1'b0;
    w_run        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (din_enable) begin
          w_state = S_RUN;
          w_base  = r_wp;
          w_k     = '0;
          w_run   = 1'b1;
        end
      end
      S_RUN: begin
        if (r_k == K_LAST) begin
          w_state = S_DRAIN;
          w_drain = '0;
        end else begin
          w_k   = r_k + 1'b1;
          w_run = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == D_LAST) w_state = S_DONE;
        else                   w_drain = r_drain + 1'b1;
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Newest sample sits at base; tap 2k reaches back 2k samples in the circular RAM.
    w_even = w_base - {w_k, 1'b0};
    w_odd  = w_even - 1'b1;

    if (w_run) begin
      w_coeff      = w_k;
      w_raddr0     = w_even;
      w_raddr1     = w_odd;
      w_mac_enable = 1'b1;
      w_mac_clear  = (w_k == '0);
      w_mac_last   = (w_k == K_LAST);
    end

    if (w_state == S_DONE) begin
      w_dout_load = 1'b1;
      w_coeff     = '0;
      w_raddr0    = '0;
      w_raddr1    = '0;
    end

    w_busy = (w_state != S_IDLE);

    // A strobe landing during a computation wins over a simultaneous clear.
    if (din_enable && r_busy) w_overrun = 1'b1;
    else if (overrun_clear)   w_overrun = 1'b0;
    else                      w_overrun = r_overrun;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wp         <= '0;
      r_base       <= '0;
      r_k          <= '0;
      r_drain      <= '0;
      r_coeff      <= '0;
      r_raddr0     <= '0;
      r_raddr1     <= '0;
      r_mac_enable <= 1'b0;
      r_mac_clear  <= 1'b0;
      r_mac_last   <= 1'b0;
      r_dout_load  <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state;
      if (din_enable) r_wp <= r_wp + 1'b1;
      r_base       <= w_base;
      r_k          <= w_k;
      r_drain      <= w_drain;
      r_coeff      <= w_coeff;
      r_raddr0     <= w_raddr0;
      r_raddr1     <= w_raddr1;
      r_mac_enable <= w_mac_enable;
      r_mac_clear  <= w_mac_clear;
      r_mac_last   <= w_mac_last;
      r_dout_load  <= w_dout_load;
      r_busy       <= w_busy;
      r_overrun    <= w_overrun;
    end
  end

  assign sample_we     = din_enable;
  assign sample_waddr  = r_wp;
  assign sample_raddr0 = r_raddr0;
  assign sample_raddr1 = r_raddr1;
  assign coeffaddress  = r_coeff;
  assign mac_enable    = r_mac_enable;
  assign mac_clear     = r_mac_clear;
  assign mac_last      = r_mac_last;
  assign dout_load     = r_dout_load;
  assign busy          = r_busy;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_filterbank_sequencer.sv
// tb/tb_filterbank_sequencer.sv - Timeline-model and directed-vector bench for filterbank_sequencer

module tb_filterbank_sequencer;

  localparam int NTAPS   = 128;
  localparam int MAC_LAT = 2;
  localparam int NPAIR   = NTAPS / 2;
  localparam int LASTN   = NPAIR + 1 + MAC_LAT;

  logic       clock = 1'b0;
  logic       reset;
  logic       din_enable;
  logic       overrun_clear;
  logic       sample_we;
  logic [6:0] sample_waddr;
  logic [6:0] sample_raddr0;
  logic [6:0] sample_raddr1;
  logic [5:0] coeffaddress;
  logic       mac_enable;
  logic       mac_clear;
  logic       mac_last;
  logic       dout_load;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  filterbank_sequencer #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .din_enable    (din_enable),
    .overrun_clear (overrun_clear),
    .sample_we     (sample_we),
    .sample_waddr  (sample_waddr),
    .sample_raddr0 (sample_raddr0),
    .sample_raddr1 (sample_raddr1),
    .coeffaddress  (coeffaddress),
    .mac_enable    (mac_enable),
    .mac_clear     (mac_clear),
    .mac_last      (mac_last),
    .dout_load     (dout_load),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a computation is a timeline of labels 1..LASTN after the accepting edge.
  int edge_cnt = 0;
  int m_start  = 0;
  bit m_active = 1'b0;
  int m_wp     = 0;
  int m_base   = 0;
  bit m_overrun = 1'b0;

  function automatic bit m_busy_before_edge();
    return m_active && ((edge_cnt - m_start) <= LASTN);
  endfunction

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_wp      <= 0;
      m_active  <= 1'b0;
      m_overrun <= 1'b0;
      m_base    <= 0;
    end else begin
      if (din_enable) begin
        m_wp <= (m_wp + 1) % NTAPS;
        if (!m_busy_before_edge()) begin
          m_active <= 1'b1;
          m_start  <= edge_cnt;
          m_base   <= m_wp;
        end
      end
      if (din_enable && m_busy_before_edge()) m_overrun <= 1'b1;
      else if (overrun_clear)                 m_overrun <= 1'b0;
    end
  end

  int mac_cnt  = 0;
  int dout_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      int n, k, e_busy, e_men, e_clr, e_last, e_dl, e_r0, e_r1, e_ca;
      bit chk_addr;
      n = edge_cnt - m_start;
      e_busy = 0; e_men = 0; e_clr = 0; e_last = 0; e_dl = 0;
      e_r0 = 0; e_r1 = 0; e_ca = 0; chk_addr = 1'b1;
      if (m_active && n >= 1 && n <= LASTN) begin
        e_busy = 1;
        if (n <= NPAIR + 1 + MAC_LAT - 1) begin
          k = (n <= NPAIR) ? n - 1 : NPAIR - 1;
          e_ca = k;
          e_r0 = (m_base - 2 * k) & (NTAPS - 1);
          e_r1 = (m_base - 2 * k - 1) & (NTAPS - 1);
          if (n <= NPAIR) begin
            e_men  = 1;
            e_clr  = (k == 0) ? 1 : 0;
            e_last = (k == NPAIR - 1) ? 1 : 0;
          end
        end else begin
          e_dl = 1;
          chk_addr = 1'b0;
        end
      end
      chk("sample_we", int'(sample_we), int'(din_enable));
      chk("sample_waddr", int'(sample_waddr), m_wp);
      chk("busy", int'(busy), e_busy);
      chk("mac_enable", int'(mac_enable), e_men);
      chk("mac_clear", int'(mac_clear), e_clr);
      chk("mac_last", int'(mac_last), e_last);
      chk("dout_load", int'(dout_load), e_dl);
      chk("overrun", int'(overrun), int'(m_overrun));
      if (chk_addr) begin
        chk("coeffaddress", int'(coeffaddress), e_ca);
        chk("sample_raddr0", int'(sample_raddr0), e_r0);
        chk("sample_raddr1", int'(sample_raddr1), e_r1);
      end
      if (mac_enable) mac_cnt <= mac_cnt + 1;
      if (dout_load)  dout_cnt <= dout_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int s_waddr;
  int s_we;

  // Drives a one-cycle strobe; returns 1 after the accepting edge (label 1).
  task automatic strobe();
    din_enable = 1'b1;
    #1;
    s_waddr = int'(sample_waddr);
    s_we    = int'(sample_we);
    @(posedge clock);
    #1;
    din_enable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_mac, snap_dout;
    reset = 1'b1;
    din_enable = 1'b0;
    overrun_clear = 1'b0;
    step(3);
    @(negedge clock);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coeff", int'(coeffaddress), 0);
    chk("rst_raddr0", int'(sample_raddr0), 0);
    chk("rst_raddr1", int'(sample_raddr1), 0);
    chk("rst_mac_enable", int'(mac_enable), 0);
    chk("rst_dout_load", int'(dout_load), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_waddr", int'(sample_waddr), 0);
    reset = 1'b0;
    step(2);

    // Single sample from reset
    snap_mac = mac_cnt;
    snap_dout = dout_cnt;
    strobe();
    chk("single_waddr", s_waddr, 0);
    chk("single_we", s_we, 1);
    @(negedge clock);
    chk("single_k0_coeff", int'(coeffaddress), 0);
    chk("single_k0_raddr0", int'(sample_raddr0), 0);
    chk("single_k0_raddr1", int'(sample_raddr1), 127);
    chk("single_k0_clear", int'(mac_clear), 1);
    step(63);
    @(negedge clock);
    chk("single_k63_coeff", int'(coeffaddress), 63);
    chk("single_k63_raddr0", int'(sample_raddr0), 2);
    chk("single_k63_raddr1", int'(sample_raddr1), 1);
    chk("single_k63_last", int'(mac_last), 1);
    step(3);
    @(negedge clock);
    chk("single_dout_t67", int'(dout_load), 1);
    step(3);
    @(negedge clock);
    chk("single_mac_count", mac_cnt - snap_mac, 64);
    chk("single_dout_count", dout_cnt - snap_dout, 1);

    // Asynchronous reset at k=20 (base 1)
    strobe();
    step(20);
    @(negedge clock);
    chk("k20_coeff", int'(coeffaddress), 20);
    chk("k20_raddr0", int'(sample_raddr0), 89);
    chk("k20_raddr1", int'(sample_raddr1), 88);
    #2;
    reset = 1'b1;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_mac_enable", int'(mac_enable), 0);
    chk("async_coeff", int'(coeffaddress), 0);
    chk("async_raddr0", int'(sample_raddr0), 0);
    chk("async_raddr1", int'(sample_raddr1), 0);
    chk("async_waddr", int'(sample_waddr), 0);
    step(1);
    reset = 1'b0;
    step(1);

    // Overrun: base 0, second strobe at T+30
    snap_dout = dout_cnt;
    strobe();
    chk("post_reset_waddr", s_waddr, 0);
    @(negedge clock);
    chk("post_reset_coeff", int'(coeffaddress), 0);
    chk("post_reset_clear", int'(mac_clear), 1);
    step(29);
    din_enable = 1'b1;
    #1;
    chk("ovr_we", int'(sample_we), 1);
    chk("ovr_waddr", int'(sample_waddr), 1);
    step(1);
    din_enable = 1'b0;
    @(negedge clock);
    chk("ovr_flag_t31", int'(overrun), 1);
    chk("ovr_coeff_t31", int'(coeffaddress), 30);
    chk("ovr_raddr0_t31", int'(sample_raddr0), 68);
    chk("ovr_raddr1_t31", int'(sample_raddr1), 67);
    step(36);
    @(negedge clock);
    chk("ovr_dout_t67", int'(dout_load), 1);
    step(3);
    @(negedge clock);
    chk("ovr_dout_count", dout_cnt - snap_dout, 1);
    overrun_clear = 1'b1;
    step(1);
    overrun_clear = 1'b0;
    @(negedge clock);
    chk("ovr_cleared", int'(overrun), 0);

    // Set/clear collision
    strobe();
    step(9);
    din_enable = 1'b1;
    overrun_clear = 1'b1;
    step(1);
    din_enable = 1'b0;
    overrun_clear = 1'b0;
    @(negedge clock);
    chk("collision_set_wins", int'(overrun), 1);
    step(62);
    overrun_clear = 1'b1;
    step(1);
    overrun_clear = 1'b0;

    // Back-to-back at minimum spacing
    strobe();
    step(66);
    @(negedge clock);
    chk("b2b_dout_t67", int'(dout_load), 1);
    chk("b2b_busy_t67", int'(busy), 1);
    step(1);
    @(negedge clock);
    chk("b2b_busy_t68", int'(busy), 0);
    strobe();
    @(negedge clock);
    chk("b2b_clear_t69", int'(mac_clear), 1);
    chk("b2b_busy_t69", int'(busy), 1);
    chk("b2b_overrun", int'(overrun), 0);
    step(70);

    // Pointer wrap: 130 strobes from reset
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    for (int i = 1; i <= 130; i++) begin
      strobe();
      if (i == 128) chk("wrap_waddr_127", s_waddr, 127);
      if (i == 129) chk("wrap_waddr_0", s_waddr, 0);
      if (i == 130) begin
        @(negedge clock);
        chk("wrap_k0_raddr0", int'(sample_raddr0), 1);
        chk("wrap_k0_raddr1", int'(sample_raddr1), 0);
        step(1);
        @(negedge clock);
        chk("wrap_k1_raddr0", int'(sample_raddr0), 127);
        chk("wrap_k1_raddr1", int'(sample_raddr1), 126);
        step(98);
      end else begin
        step(99);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
